// File: rtl/i2s_rx_if.sv
// rtl/i2s_rx_if.sv - capture FIFO write port carrying packed {left,right} frames
interface i2s_rx_if #(
    parameter int WORD_BITS = 16
);
    logic [2*WORD_BITS-1:0] AUDIO;
    logic                   FIFO_WRITE;
    logic                   FIFO_FULL;

    modport master (
        output AUDIO,
        output FIFO_WRITE,
        input  FIFO_FULL
    );

    modport slave (
        input  AUDIO,
        input  FIFO_WRITE,
        output FIFO_FULL
    );
endinterface

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receiver deserialising codec DOUT into stereo frames on MCLK
module i2s_rx #(
    parameter int WORD_BITS = 16,
    parameter int DROP_W    = 8
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic              SCLK,
    input  logic              LRCLK,
    input  logic              DOUT,
    i2s_rx_if.master          fifo,
    output logic              OVERFLOW,
    output logic              FRAME_ERR,
    output logic [DROP_W-1:0] DROP_COUNT
);
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {SYNC, SHIFT_L, WAIT_L, SHIFT_R, WAIT_R} state_t;

    logic                   s_sclk_q, s_lr_q, s_dout_q;
    logic                   sclk_prev_q, lr_prev_q, lr_prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_BITS-1:0]   left_sr_q, left_sr_d;
    logic [WORD_BITS-1:0]   right_sr_q, right_sr_d;
    logic                   complete_q, complete_d;
    logic [2*WORD_BITS-1:0] audio_q, audio_d;
    logic                   write_q, write_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_err_q, frame_err_d;
    logic [DROP_W-1:0]      drop_q, drop_d;

    logic bit_tick, boundary, last_bit;

    always_comb begin
        bit_tick    = s_sclk_q & ~sclk_prev_q;
        boundary    = bit_tick & (s_lr_q != lr_prev_q);
        last_bit    = (count_q == CNT_W'(WORD_BITS - 1));
        lr_prev_d   = bit_tick ? s_lr_q : lr_prev_q;
        state_d     = state_q;
        count_d     = count_q;
        left_sr_d   = left_sr_q;
        right_sr_d  = right_sr_q;
        complete_d  = 1'b0;
        audio_d     = audio_q;
        write_d     = 1'b0;
        overflow_d  = overflow_q;
        frame_err_d = frame_err_q;
        drop_d      = drop_q;

        // The cycle after the final right bit decides between write and drop.
        if (complete_q) begin
            if (fifo.FIFO_FULL) begin
                overflow_d = 1'b1;
                if (drop_q != {DROP_W{1'b1}}) begin
                    drop_d = drop_q + DROP_W'(1);
                end
            end else begin
                write_d = 1'b1;
                audio_d = {left_sr_q, right_sr_q};
            end
        end

        if (bit_tick) begin
            case (state_q)
                SYNC: begin
                    if (boundary && !s_lr_q) begin
                        state_d = SHIFT_L;
                        count_d = '0;
                    end
                end
                SHIFT_L: begin
                    if (boundary) begin
                        frame_err_d = 1'b1;
                        state_d     = s_lr_q ? SYNC : SHIFT_L;
                        count_d     = '0;
                    end else begin
                        left_sr_d = {left_sr_q[WORD_BITS-2:0], s_dout_q};
                        count_d   = count_q + CNT_W'(1);
                        if (last_bit) state_d = WAIT_L;
                    end
                end
                WAIT_L: begin
                    if (boundary && s_lr_q) begin
                        state_d = SHIFT_R;
                        count_d = '0;
                    end
                end
                SHIFT_R: begin
                    if (boundary) begin
                        frame_err_d = 1'b1;
                        state_d     = s_lr_q ? SYNC : SHIFT_L;
                        count_d     = '0;
                    end else begin
                        right_sr_d = {right_sr_q[WORD_BITS-2:0], s_dout_q};
                        count_d    = count_q + CNT_W'(1);
                        if (last_bit) begin
                            state_d    = WAIT_R;
                            complete_d = 1'b1;
                        end
                    end
                end
                WAIT_R: begin
                    // Left boundary closes this frame and opens the next one directly.
                    if (boundary && !s_lr_q) begin
                        state_d = SHIFT_L;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = SYNC;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            s_sclk_q    <= 1'b0;
            s_lr_q      <= 1'b0;
            s_dout_q    <= 1'b0;
            sclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            state_q     <= SYNC;
            count_q     <= '0;
            left_sr_q   <= '0;
            right_sr_q  <= '0;
            complete_q  <= 1'b0;
            audio_q     <= '0;
            write_q     <= 1'b0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            drop_q      <= '0;
        end else begin
            s_sclk_q    <= SCLK;
            s_lr_q      <= LRCLK;
            s_dout_q    <= DOUT;
            sclk_prev_q <= s_sclk_q;
            lr_prev_q   <= lr_prev_d;
            state_q     <= state_d;
            count_q     <= count_d;
            left_sr_q   <= left_sr_d;
            right_sr_q  <= right_sr_d;
            complete_q  <= complete_d;
            audio_q     <= audio_d;
            write_q     <= write_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            drop_q      <= drop_d;
        end
    end

    assign fifo.AUDIO      = audio_q;
    assign fifo.FIFO_WRITE = write_q;
    assign OVERFLOW        = overflow_q;
    assign FRAME_ERR       = frame_err_q;
    assign DROP_COUNT      = drop_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - scoreboard bench driving a codec model into i2s_rx
module tb_i2s_rx;
    localparam int WB = 16;
    localparam int DW = 8;

    logic          mclk = 1'b0;
    logic          rst, sclk, lrclk, dout;
    logic          overflow, frame_err;
    logic [DW-1:0] drop_count;

    i2s_rx_if #(.WORD_BITS(WB)) fifo_if ();

    i2s_rx #(.WORD_BITS(WB), .DROP_W(DW)) dut (
        .MCLK       (mclk),
        .RESET      (rst),
        .SCLK       (sclk),
        .LRCLK      (lrclk),
        .DOUT       (dout),
        .fifo       (fifo_if.master),
        .OVERFLOW   (overflow),
        .FRAME_ERR  (frame_err),
        .DROP_COUNT (drop_count)
    );

    always #5 mclk = ~mclk;

    int          checks = 0;
    int          errors = 0;
    int          half = 2;
    int          drop_exp = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_audio = 32'h0;
    logic [31:0] mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge mclk) begin
        if (fifo_if.FIFO_WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {31'b0, fifo_if.FIFO_WRITE}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("audio", fifo_if.AUDIO, mon_e);
                last_audio = mon_e;
            end
        end
    end

    task automatic send_bit(input logic lr, input logic d);
        sclk  = 1'b0;
        lrclk = lr;
        dout  = d;
        repeat (half) @(posedge mclk);
        #1;
        sclk = 1'b1;
        repeat (half) @(posedge mclk);
        #1;
    endtask

    task automatic send_slot(input logic lr, input logic [WB-1:0] data, input int nbits);
        send_bit(lr, 1'($urandom));
        for (int i = 0; i < WB; i++) send_bit(lr, data[WB-1-i]);
        for (int i = 0; i < nbits - 1 - WB; i++) send_bit(lr, 1'($urandom));
    endtask

    task automatic send_frame(input logic [WB-1:0] l, input logic [WB-1:0] r, input int nbits);
        if (fifo_if.FIFO_FULL) begin
            if (drop_exp < 255) drop_exp++;
        end else begin
            exp_q.push_back({l, r});
        end
        send_slot(1'b0, l, nbits);
        send_slot(1'b1, r, nbits);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sclk = 1'b0; lrclk = 1'b0; dout = 1'b0;
        fifo_if.FIFO_FULL = 1'b0;
        idle(3);
        check("rst_audio", fifo_if.AUDIO, 32'h0);
        check("rst_write", {31'b0, fifo_if.FIFO_WRITE}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        check("rst_frame_err", {31'b0, frame_err}, 32'h0);
        check("rst_drop", {24'b0, drop_count}, 32'h0);
        rst = 1'b0;

        // Single frame preceded by a right slot so the left boundary is seen
        send_slot(1'b1, 16'($urandom), 32);
        send_frame(16'hA5A5, 16'h1234, 32);
        idle(6);
        check("t1_pending", exp_q.size(), 0);
        check("t1_audio", fifo_if.AUDIO, 32'hA5A51234);
        check("t1_overflow", {31'b0, overflow}, 32'h0);
        check("t1_frame_err", {31'b0, frame_err}, 32'h0);

        send_frame(16'h0001, 16'h8000, 32);
        send_frame(16'hFFFF, 16'h0000, 32);
        send_frame(16'h7FFF, 16'h8001, 32);
        idle(6);
        check("t2_pending", exp_q.size(), 0);
        check("t2_audio", fifo_if.AUDIO, 32'h7FFF8001);

        // Reset spans a left slot and part of a right slot
        rst = 1'b1;
        send_slot(1'b0, 16'hDEAD, 32);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'($urandom));
        rst = 1'b0;
        for (int i = 0; i < 27; i++) send_bit(1'b1, 1'($urandom));
        send_frame(16'h1357, 16'h2468, 32);
        idle(6);
        check("t3_pending", exp_q.size(), 0);
        check("t3_audio", fifo_if.AUDIO, 32'h13572468);

        fifo_if.FIFO_FULL = 1'b1;
        half = 1;
        drop_exp = 0;
        for (int f = 0; f < 300; f++) send_frame(16'($urandom), 16'($urandom), WB + 1);
        idle(4);
        check("t4_overflow", {31'b0, overflow}, 32'h1);
        check("t4_drop", {24'b0, drop_count}, 32'(drop_exp));
        check("t4_drop_sat", {24'b0, drop_count}, 32'd255);
        check("t4_audio_held", fifo_if.AUDIO, last_audio);
        check("t4_pending", exp_q.size(), 0);
        fifo_if.FIFO_FULL = 1'b0;
        send_frame(16'hBEEF, 16'hCAFE, WB + 1);
        half = 2;
        idle(6);
        check("t4_post_pending", exp_q.size(), 0);
        check("t4_post_audio", fifo_if.AUDIO, 32'hBEEFCAFE);
        check("t4_post_overflow", {31'b0, overflow}, 32'h1);

        // Left slot cut short after 10 data bits
        send_bit(1'b0, 1'($urandom));
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'($urandom));
        send_slot(1'b1, 16'($urandom), 32);
        idle(4);
        check("t5_frame_err", {31'b0, frame_err}, 32'h1);
        check("t5_no_write", exp_q.size(), 0);
        send_frame(16'h1111, 16'h2222, 32);
        idle(6);
        check("t5_pending", exp_q.size(), 0);
        check("t5_audio", fifo_if.AUDIO, 32'h11112222);

        send_slot(1'b0, 16'h5555, 32);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t6_audio", fifo_if.AUDIO, 32'h0);
        check("t6_write", {31'b0, fifo_if.FIFO_WRITE}, 32'h0);
        check("t6_overflow", {31'b0, overflow}, 32'h0);
        check("t6_frame_err", {31'b0, frame_err}, 32'h0);
        check("t6_drop", {24'b0, drop_count}, 32'h0);
        send_slot(1'b1, 16'hAAAA, 32);
        idle(4);
        check("t6_no_write", fifo_if.AUDIO, 32'h0);
        send_frame(16'h0F0F, 16'hF0F0, 32);
        idle(6);
        check("t6_pending", exp_q.size(), 0);
        check("t6_audio_resync", fifo_if.AUDIO, 32'h0F0FF0F0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
